instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 44 ++++
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bus between the instruction fetch unit, its instruction memory port,
// the execute-stage redirect and the downstream decode handshake.
interface instr_fetch_if #(
  parameter int n = 8
);
  logic [n-1:0] mem_rd_addr1;
  logic [n-1:0] mem_rd_data1;
  logic         redirect_valid;
  logic [n-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_ir;
  logic [n-1:0] out_imm;
  logic         out_has_imm;
  logic [n-1:0] out_pc;

  // Fetch unit side
  modport master (
    output mem_rd_addr1,
    input  mem_rd_data1,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_ir,
    output out_imm,
    output out_has_imm,
    output out_pc
  );

  // Memory, execute and decode side
  modport slave (
    input  mem_rd_addr1,
    output mem_rd_data1,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_ir,
    input  out_imm,
    input  out_has_imm,
    input  out_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: assembles one- and two-byte instructions
// into packets and queues them in a 2-entry FIFO for decode.
module instr_fetch #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  localparam logic [0:0] S_OP  = 1'b0;
  localparam logic [0:0] S_IMM = 1'b1;

  logic [0:0]   r_state;
  logic [n-1:0] r_pc;
  logic [n-1:0] r_stageIr;
  logic [n-1:0] r_stagePc;
  logic         r_head;
  logic [1:0]   r_count;

  logic [n-1:0] r_fifoIr  [2];
  logic [n-1:0] r_fifoImm [2];
  logic [n-1:0] r_fifoPc  [2];
  logic         r_fifoHas [2];

  logic [2:0]   w_opcode;
  logic         w_twoByte;
  logic         w_pop;
  logic         w_pushOk;
  logic         w_push;
  logic         w_stage;
  logic         w_tail;
  logic [n-1:0] w_pushIr;
  logic [n-1:0] w_pushImm;
  logic         w_pushHas;
  logic [n-1:0] w_pushPc;

  assign w_opcode  = bus.mem_rd_data1[n-1 -: 3];
  assign w_twoByte = (w_opcode != 3'b000) && (w_opcode != 3'b010) && (w_opcode != 3'b100);

  assign w_pop    = bus.out_valid && bus.out_ready;
  assign w_pushOk = (r_count != 2'd2) || w_pop;

  // Latching the opcode of a two-byte instruction never needs queue space.
  assign w_push  = !bus.redirect_valid && w_pushOk && ((r_state == S_IMM) || !w_twoByte);
  assign w_stage = !bus.redirect_valid && (r_state == S_OP) && w_twoByte;
  assign w_tail  = r_head ^ r_count[0];

  always_comb begin
    w_pushIr  = bus.mem_rd_data1;
    w_pushImm = '0;
    w_pushHas = 1'b0;
    w_pushPc  = r_pc;
    if (r_state == S_IMM) begin
      w_pushIr  = r_stageIr;
      w_pushImm = bus.mem_rd_data1;
      w_pushHas = 1'b1;
      w_pushPc  = r_stagePc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_OP;
      r_pc      <= '0;
      r_stageIr <= '0;
      r_stagePc <= '0;
      r_head    <= 1'b0;
      r_count   <= 2'd0;
    end else if (bus.redirect_valid) begin
      r_state   <= S_OP;
      r_pc      <= bus.redirect_pc;
      r_stageIr <= '0;
      r_stagePc <= '0;
      r_head    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_stage) begin
        r_stageIr <= bus.mem_rd_data1;
        r_stagePc <= r_pc;
        r_state   <= S_IMM;
        r_pc      <= r_pc + 1'b1;
      end else if (w_push) begin
        r_state <= S_OP;
        r_pc    <= r_pc + 1'b1;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // On push-with-pop at full, the tail slot is the head being vacated.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoIr[w_tail]  <= w_pushIr;
      r_fifoImm[w_tail] <= w_pushImm;
      r_fifoHas[w_tail] <= w_pushHas;
      r_fifoPc[w_tail]  <= w_pushPc;
    end
  end

  assign bus.mem_rd_addr1 = r_pc;
  assign bus.out_valid    = (r_count != 2'd0);
  assign bus.out_ir       = bus.out_valid ? r_fifoIr[r_head]  : '0;
  assign bus.out_imm      = bus.out_valid ? r_fifoImm[r_head] : '0;
  assign bus.out_has_imm  = bus.out_valid ? r_fifoHas[r_head] : 1'b0;
  assign bus.out_pc       = bus.out_valid ? r_fifoPc[r_head]  : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected packets go into a scoreboard
// queue and a negedge monitor checks every accepted packet against it.
module tb_instr_fetch;

  logic clk;
  logic reset;
  logic [7:0] mem [256];
  logic [24:0] expQ [$];
  int vectorCount;
  int missCount;

  instr_fetch_if #(.n(8)) bus ();

  instr_fetch #(.n(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_rd_data1 = mem[bus.mem_rd_addr1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rv, input logic [7:0] rpc, input logic rdy);
    reset              = rst;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [7:0] ir, input logic [7:0] imm, input logic has, input logic [7:0] pc);
    expQ.push_back({ir, imm, has, pc});
  endtask

  task automatic checkIdle(input string tag, input logic [7:0] addr);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, ".ir"}, 32'(bus.out_ir), 32'd0);
    checkOutput({tag, ".imm"}, 32'(bus.out_imm), 32'd0);
    checkOutput({tag, ".hasImm"}, 32'(bus.out_has_imm), 32'd0);
    checkOutput({tag, ".pc"}, 32'(bus.out_pc), 32'd0);
    checkOutput({tag, ".addr"}, 32'(bus.mem_rd_addr1), 32'(addr));
  endtask

  // Every packet accepted by decode must be the next one the stimulus predicted.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        vectorCount++;
        missCount++;
        $display("[TB] FAIL unexpectedPop: got ir=0x%0h pc=0x%0h, expected no packet", bus.out_ir, bus.out_pc);
      end else begin
        logic [24:0] expPkt;
        expPkt = expQ.pop_front();
        checkOutput("packet", 32'({bus.out_ir, bus.out_imm, bus.out_has_imm, bus.out_pc}), 32'(expPkt));
      end
    end
  end

  initial begin
    vectorCount        = 0;
    missCount          = 0;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    bus.out_ready      = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkIdle("reset", 8'h00);

    mem[1] = 8'h08;
    pushExp(8'h00, 8'h00, 1'b0, 8'h00);
    pushExp(8'h08, 8'h00, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("oneByte.validC1", 32'(bus.out_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("oneByte.validC2", 32'(bus.out_valid), 32'd1);
    checkOutput("oneByte.headPc", 32'(bus.out_pc), 32'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkIdle("reset2", 8'h00);
    mem[0] = 8'h22;
    mem[1] = 8'h05;
    mem[2] = 8'h40;
    mem[3] = 8'h00;
    pushExp(8'h22, 8'h05, 1'b1, 8'h00);
    pushExp(8'h40, 8'h00, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("twoByte.validAfterOp", 32'(bus.out_valid), 32'd0);
    checkOutput("twoByte.addrImm", 32'(bus.mem_rd_addr1), 32'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("twoByte.validAfterImm", 32'(bus.out_valid), 32'd1);
    checkOutput("twoByte.addr", 32'(bus.mem_rd_addr1), 32'h02);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    mem[0] = 8'h10;
    mem[1] = 8'h48;
    mem[2] = 8'h80;
    mem[3] = 8'h0C;
    mem[4] = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("stall.addr", 32'(bus.mem_rd_addr1), 32'h02);
    checkOutput("stall.valid", 32'(bus.out_valid), 32'd1);
    checkOutput("stall.headPc", 32'(bus.out_pc), 32'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("stall.addrHeld", 32'(bus.mem_rd_addr1), 32'h02);
    pushExp(8'h10, 8'h00, 1'b0, 8'h00);
    pushExp(8'h48, 8'h00, 1'b0, 8'h01);
    pushExp(8'h80, 8'h00, 1'b0, 8'h02);
    pushExp(8'h0C, 8'h00, 1'b0, 8'h03);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("full.headPc", 32'(bus.out_pc), 32'h03);

    // Redirect with the FIFO full and the head being accepted in the same cycle.
    mem[8'h40] = 8'h64;
    mem[8'h41] = 8'h33;
    mem[8'h42] = 8'h00;
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b1);
    checkOutput("redirect.valid", 32'(bus.out_valid), 32'd0);
    checkOutput("redirect.addr", 32'(bus.mem_rd_addr1), 32'h40);
    pushExp(8'h64, 8'h33, 1'b1, 8'h40);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("redirect.validOp", 32'(bus.out_valid), 32'd0);
    checkOutput("redirect.addrImm", 32'(bus.mem_rd_addr1), 32'h41);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("redirect.pktPc", 32'(bus.out_pc), 32'h40);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    mem[8'hFF] = 8'hC2;
    mem[0]     = 8'hFE;
    mem[3]     = 8'h22;
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
    checkOutput("wrap.validAfterRedirect", 32'(bus.out_valid), 32'd0);
    checkOutput("wrap.addrFF", 32'(bus.mem_rd_addr1), 32'hFF);
    pushExp(8'hC2, 8'hFE, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("wrap.addr00", 32'(bus.mem_rd_addr1), 32'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("wrap.addr01", 32'(bus.mem_rd_addr1), 32'h01);
    checkOutput("wrap.headPc", 32'(bus.out_pc), 32'hFF);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("immFull.addr", 32'(bus.mem_rd_addr1), 32'h04);
    checkOutput("immFull.valid", 32'(bus.out_valid), 32'd1);
    checkOutput("immFull.headPc", 32'(bus.out_pc), 32'h01);

    // Reset and redirect raised mid-cycle: nothing may change before the edge.
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h77;
    #2;
    checkOutput("syncReset.validHeld", 32'(bus.out_valid), 32'd1);
    checkOutput("syncReset.addrHeld", 32'(bus.mem_rd_addr1), 32'h04);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    checkIdle("resetInImm", 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("afterReset.valid", 32'(bus.out_valid), 32'd0);
    checkOutput("afterReset.addr", 32'(bus.mem_rd_addr1), 32'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("afterReset.pktValid", 32'(bus.out_valid), 32'd1);
    checkOutput("afterReset.pktIr", 32'(bus.out_ir), 32'hFE);
    checkOutput("afterReset.pktImm", 32'(bus.out_imm), 32'h48);
    checkOutput("afterReset.pktHasImm", 32'(bus.out_has_imm), 32'd1);
    checkOutput("afterReset.pktPc", 32'(bus.out_pc), 32'h00);

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
